// File: rtl/debug_display_sequencer_pkg.sv
// Shared constants for the debug display sequencer: default display patterns,
// channel numbering used to pack Channels_In, and selection-source encodings.
package debug_display_sequencer_pkg;

  localparam logic [31:0] DEF_OFF_PATTERN = 32'h0000_0FF0;
  localparam logic [31:0] DEF_ERR_PATTERN = 32'h0000_DEDE;

  // Channel numbers used by the processor debug taps when packing Channels_In.
  localparam int unsigned CH_STAGE    = 0;
  localparam int unsigned CH_PC       = 1;
  localparam int unsigned CH_IR       = 2;
  localparam int unsigned CH_RA       = 3;
  localparam int unsigned CH_RB       = 4;
  localparam int unsigned CH_RZ       = 5;
  localparam int unsigned CH_RM       = 6;
  localparam int unsigned CH_RY       = 7;
  localparam int unsigned CH_CCR      = 8;
  localparam int unsigned CH_MAR      = 9;
  localparam int unsigned CH_MDR      = 10;
  localparam int unsigned CH_IMM      = 11;
  localparam int unsigned CH_ALU_OP   = 12;
  localparam int unsigned CH_BR_TGT   = 13;
  localparam int unsigned CH_PC_TEMP  = 14;
  localparam int unsigned CH_RF_WADDR = 15;
  localparam int unsigned CH_MEM_ADDR = 16;
  localparam int unsigned CH_MEM_DATA = 17;
  localparam int unsigned CH_CTRL     = 18;
  localparam int unsigned CH_IFMT     = 19;
  localparam int unsigned CH_COUNT    = 20;

  typedef enum logic [1:0] {
    IDX_HOLD,
    IDX_LOAD,
    IDX_STEP,
    IDX_SCAN
  } idx_src_e;

  typedef enum logic [1:0] {
    DSP_LIVE,
    DSP_ERR,
    DSP_HOLD,
    DSP_OFF
  } dsp_src_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debug_display_sequencer_scan_timer.sv
// Auto-scan tick generator: pulses Tick once every SCAN_DIV enabled cycles.
module dbg_scan_timer #(
  parameter int unsigned SCAN_DIV = 50_000_000,
  localparam int unsigned CNT_W = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV)
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  input  logic Clear,
  output logic Tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_end;

  assign at_end = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign Tick   = Enable & at_end;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!Enable || Clear || at_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/debug_display_sequencer.sv
// Clocked debug display selector: load/step/auto-scan channel index with a
// registered display word supporting freeze snapshots and blank/error patterns.
module debug_display_sequencer
  import debug_display_sequencer_pkg::*;
#(
  parameter int unsigned         N_CHANNELS  = 20,
  parameter int unsigned         DATA_W      = 32,
  parameter int unsigned         SCAN_DIV    = 50_000_000,
  parameter logic [DATA_W-1:0]   OFF_PATTERN = DATA_W'(DEF_OFF_PATTERN),
  parameter logic [DATA_W-1:0]   ERR_PATTERN = DATA_W'(DEF_ERR_PATTERN),
  localparam int unsigned        SEL_W       = sel_width(N_CHANNELS)
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [N_CHANNELS*DATA_W-1:0] Channels_In,
  input  logic [SEL_W-1:0]             Display_Select,
  input  logic                         Load_Select,
  input  logic                         Step,
  input  logic                         Auto_Scan,
  input  logic                         Freeze,
  input  logic                         Display_Blank,
  output logic [DATA_W-1:0]            HexDisplay32Bits,
  output logic [SEL_W-1:0]             Current_Channel,
  output logic                         Select_Error,
  output logic                         Frozen
);

  logic [SEL_W-1:0]  idx_q, idx_d, idx_inc;
  logic              step_q;
  logic              step_rise;
  logic              scan_tick;
  logic              scan_clear;
  logic              sel_err_d;
  logic [DATA_W-1:0] hex_q, hex_d;
  logic [DATA_W-1:0] chan_word;
  logic              err_q;
  logic              frozen_q;
  idx_src_e          idx_src;
  dsp_src_e          dsp_src;

  assign step_rise  = Step & ~step_q;
  assign scan_clear = Load_Select | step_rise;

  dbg_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (Auto_Scan),
    .Clear  (scan_clear),
    .Tick   (scan_tick)
  );

  // Out-of-range indices wrap to channel 0 just like the last valid channel.
  assign idx_inc = (32'(idx_q) >= N_CHANNELS - 1) ? '0 : idx_q + SEL_W'(1);

  always_comb begin
    idx_src = IDX_HOLD;
    if (Load_Select) begin
      idx_src = IDX_LOAD;
    end else if (step_rise) begin
      idx_src = IDX_STEP;
    end else if (scan_tick) begin
      idx_src = IDX_SCAN;
    end

    case (idx_src)
      IDX_LOAD: idx_d = Display_Select;
      IDX_STEP,
      IDX_SCAN: idx_d = idx_inc;
      default:  idx_d = idx_q;
    endcase
  end

  assign sel_err_d = (32'(idx_d) >= N_CHANNELS);

  always_comb begin
    chan_word = '0;
    for (int unsigned k = 0; k < N_CHANNELS; k++) begin
      if (32'(idx_d) == k) begin
        chan_word = Channels_In[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    dsp_src = DSP_LIVE;
    if (Display_Blank) begin
      dsp_src = DSP_OFF;
    end else if (Freeze) begin
      dsp_src = DSP_HOLD;
    end else if (sel_err_d) begin
      dsp_src = DSP_ERR;
    end

    case (dsp_src)
      DSP_OFF:  hex_d = OFF_PATTERN;
      DSP_HOLD: hex_d = hex_q;
      DSP_ERR:  hex_d = ERR_PATTERN;
      default:  hex_d = chan_word;
    endcase
  end

  // step_q resets high so a Step held across reset is not taken as an edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      idx_q    <= '0;
      step_q   <= 1'b1;
      hex_q    <= '0;
      err_q    <= 1'b0;
      frozen_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      step_q   <= Step;
      hex_q    <= hex_d;
      err_q    <= sel_err_d;
      frozen_q <= Freeze;
    end
  end

  assign HexDisplay32Bits = hex_q;
  assign Current_Channel  = idx_q;
  assign Select_Error     = err_q;
  assign Frozen           = frozen_q;

endmodule

// File: tb/tb_debug_display_sequencer.sv
// Self-checking bench for debug_display_sequencer: directed table, corner
// sequences and randomized traffic against a behavioural reference model.
module tb_debug_display_sequencer;

  localparam int N  = 20;
  localparam int DW = 32;
  localparam int SD = 4;
  localparam int SW = 5;
  localparam logic [31:0] OFFP = 32'h0000_0FF0;
  localparam logic [31:0] ERRP = 32'h0000_DEDE;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] chans;
  logic [SW-1:0]   sel;
  logic            load, step, aut, frz, blk;
  logic [DW-1:0]   hex;
  logic [SW-1:0]   ch;
  logic            err, frozen;

  logic [31:0] chan_v [N];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  int          m_idx;
  bit          m_stepq;
  int          m_cnt;
  logic [31:0] m_hex;
  bit          m_frozen;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) chans[k*DW +: DW] = chan_v[k];
  end

  debug_display_sequencer #(
    .N_CHANNELS  (N),
    .DATA_W      (DW),
    .SCAN_DIV    (SD),
    .OFF_PATTERN (OFFP),
    .ERR_PATTERN (ERRP)
  ) dut (
    .Clock            (clk),
    .Reset            (rst),
    .Channels_In      (chans),
    .Display_Select   (sel),
    .Load_Select      (load),
    .Step             (step),
    .Auto_Scan        (aut),
    .Freeze           (frz),
    .Display_Blank    (blk),
    .HexDisplay32Bits (hex),
    .Current_Channel  (ch),
    .Select_Error     (err),
    .Frozen           (frozen)
  );

  function automatic int next_of(int i);
    return (i < N - 1) ? i + 1 : 0;
  endfunction

  task automatic model_edge();
    bit rise, tick;
    int nidx;
    if (rst) begin
      m_idx = 0; m_stepq = 1; m_cnt = 0; m_hex = '0; m_frozen = 0;
      return;
    end
    rise = step && !m_stepq;
    tick = aut && (m_cnt == SD - 1);
    if (load)      nidx = int'(sel);
    else if (rise) nidx = next_of(m_idx);
    else if (tick) nidx = next_of(m_idx);
    else           nidx = m_idx;
    if (!aut || load || rise) m_cnt = 0;
    else                      m_cnt = (m_cnt + 1) % SD;
    if (blk)           m_hex = OFFP;
    else if (frz)      m_hex = m_hex;
    else if (nidx >= N) m_hex = ERRP;
    else               m_hex = chan_v[nidx];
    m_idx    = nidx;
    m_stepq  = step;
    m_frozen = frz;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "/hex"},    hex,           m_hex);
    check({tag, "/ch"},     32'(ch),       32'(m_idx));
    check({tag, "/err"},    32'(err),      32'(m_idx >= N));
    check({tag, "/frozen"}, 32'(frozen),   32'(m_frozen));
  endtask

  task automatic cyc(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit          l;
    int          s;
    bit          st;
    bit          a;
    bit          f;
    bit          b;
    int          ech;
    bit          eerr;
    logic [31:0] ehex;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit l, int s, bit st, bit a, bit f, bit b,
                              int ech, bit eerr, logic [31:0] ehex);
    vec_t v;
    v.l = l; v.s = s; v.st = st; v.a = a; v.f = f; v.b = b;
    v.ech = ech; v.eerr = eerr; v.ehex = ehex;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1; load = 0; sel = '0; step = 1; aut = 0; frz = 0; blk = 0;
    for (int k = 0; k < N; k++) chan_v[k] = 32'hC0DE_0000 + 32'(k);
    m_idx = 0; m_stepq = 1; m_cnt = 0; m_hex = '0; m_frozen = 0;

    // Reset with Step held high throughout
    cyc("reset0");
    cyc("reset1");
    check("rst_hex", hex, 32'h0);
    check("rst_ch",  32'(ch), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    rst = 0;
    cyc("held_step_after_reset");
    check("held_step_ch",  32'(ch), 32'd0);
    check("held_step_hex", hex, 32'hC0DE_0000);

    //   l  sel st a f b   ch err hex
    add(0, 0,  0, 0,0,0,  0, 0, 32'hC0DE_0000);
    add(1, 7,  0, 0,0,0,  7, 0, 32'hC0DE_0007);
    add(0, 0,  0, 0,0,0,  7, 0, 32'hC0DE_0007);
    add(1, 19, 0, 0,0,0, 19, 0, 32'hC0DE_0013);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0,0,0, 0, 0, 32'hC0DE_0000);
    add(0, 0,  0, 0,0,0,  0, 0, 32'hC0DE_0000);
    add(1, 25, 0, 0,0,0, 25, 1, ERRP);
    add(0, 0,  0, 0,0,0, 25, 1, ERRP);
    add(0, 0,  1, 0,0,0,  0, 0, 32'hC0DE_0000);
    add(0, 0,  1, 0,0,0,  0, 0, 32'hC0DE_0000);
    add(0, 0,  0, 0,0,0,  0, 0, 32'hC0DE_0000);
    add(1, 3,  1, 0,0,0,  3, 0, 32'hC0DE_0003);
    add(0, 0,  1, 0,0,0,  3, 0, 32'hC0DE_0003);
    add(0, 0,  0, 0,0,0,  3, 0, 32'hC0DE_0003);
    add(0, 0,  1, 0,0,0,  4, 0, 32'hC0DE_0004);
    add(0, 0,  0, 0,0,1,  4, 0, OFFP);
    add(0, 0,  0, 0,1,1,  4, 0, OFFP);
    add(0, 0,  0, 0,1,0,  4, 0, OFFP);
    add(0, 0,  0, 0,0,0,  4, 0, 32'hC0DE_0004);

    for (int i = 0; i < tbl.size(); i++) begin
      load = tbl[i].l; sel = SW'(tbl[i].s); step = tbl[i].st;
      aut = tbl[i].a; frz = tbl[i].f; blk = tbl[i].b;
      cyc($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_ch", i),  32'(ch),  32'(tbl[i].ech));
      check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].eerr));
      check($sformatf("tbl%0d_hex", i), hex,      tbl[i].ehex);
    end
    load = 0; step = 0;

    // Auto-scan from 18 with a step mid-count
    load = 1; sel = 5'd18; cyc("scan_load");
    load = 0; aut = 1;
    for (int i = 0; i < 3; i++) cyc("scan_a");
    check("scan_still18", 32'(ch), 32'd18);
    cyc("scan_b");
    check("scan_19", 32'(ch), 32'd19);
    for (int i = 0; i < 4; i++) cyc("scan_c");
    check("scan_wrap0", 32'(ch), 32'd0);
    check("scan_wrap0_hex", hex, 32'hC0DE_0000);
    cyc("scan_d"); cyc("scan_e");
    step = 1; cyc("scan_step");
    check("scan_step_ch", 32'(ch), 32'd1);
    for (int i = 0; i < 3; i++) cyc("scan_f");
    check("scan_restart_hold", 32'(ch), 32'd1);
    cyc("scan_g");
    check("scan_restart_tick", 32'(ch), 32'd2);
    aut = 0; step = 0; cyc("scan_off");

    // Freeze snapshot while channel data and index change
    load = 1; sel = 5'd2; cyc("frz_load2");
    load = 0; frz = 1; cyc("frz_on");
    check("frz_on_hex", hex, 32'hC0DE_0002);
    check("frz_on_flag", 32'(frozen), 32'd1);
    chan_v[2] = 32'h0000_1234;
    load = 1; sel = 5'd5; cyc("frz_load5");
    check("frz_hold_hex", hex, 32'hC0DE_0002);
    check("frz_track_ch", 32'(ch), 32'd5);
    load = 0; cyc("frz_hold2");
    frz = 0; cyc("frz_off");
    check("frz_off_hex", hex, 32'hC0DE_0005);
    blk = 1; cyc("blank");
    check("blank_hex", hex, OFFP);
    frz = 1; cyc("blank_frz");
    blk = 0; cyc("unblank_frz");
    check("unblank_frz_hex", hex, OFFP);
    frz = 0; cyc("unfrz");
    check("unfrz_hex", hex, 32'hC0DE_0005);
    chan_v[2] = 32'hC0DE_0002;

    // Reset mid-scan with Step held
    aut = 1; load = 1; sel = 5'd9; cyc("mr_load");
    load = 0; cyc("mr_a"); step = 1; cyc("mr_step");
    rst = 1; cyc("mr_rst");
    rst = 0; cyc("mr_rel1"); cyc("mr_rel2");
    check("mr_held_ch", 32'(ch), 32'd0);
    step = 0; aut = 0; cyc("mr_drop");
    step = 1; cyc("mr_new_edge");
    check("mr_new_edge_ch", 32'(ch), 32'd1);
    step = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 9) == 0);
      sel  = SW'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0)  step = ~step;
      if ($urandom_range(0, 29) == 0) aut  = ~aut;
      if ($urandom_range(0, 19) == 0) frz  = ~frz;
      if ($urandom_range(0, 24) == 0) blk  = ~blk;
      if ($urandom_range(0, 4) == 0)  chan_v[$urandom_range(0, N-1)] = $urandom;
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
